// File: rtl/stoplight_phase_timer.sv
// Stoplight phase timer: follows the observed light phase, counts its dwell time
// and pulses the sequencer's advance input, shortening green for pedestrians.
module stoplight_phase_timer #(
  parameter int RED_TICKS   = 8,
  parameter int BLANK_TICKS = 1,
  parameter int YEL_TICKS   = 3,
  parameter int GRN_TICKS   = 6,
  parameter int PED_MIN     = 2,
  parameter int WAIT_LIMIT  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             r,
  input  logic             y,
  input  logic             g,
  input  logic             ped_req,
  output logic             advance,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             ped_walk,
  output logic             fault
);

  localparam logic [1:0] PH_RED   = 2'b00;
  localparam logic [1:0] PH_BLANK = 2'b01;
  localparam logic [1:0] PH_YEL   = 2'b10;
  localparam logic [1:0] PH_GRN   = 2'b11;

  localparam logic [CNT_W-1:0] RED_T   = CNT_W'(RED_TICKS);
  localparam logic [CNT_W-1:0] BLANK_T = CNT_W'(BLANK_TICKS);
  localparam logic [CNT_W-1:0] YEL_T   = CNT_W'(YEL_TICKS);
  localparam logic [CNT_W-1:0] GRN_T   = CNT_W'(GRN_TICKS);
  localparam logic [CNT_W-1:0] PED_T   = CNT_W'(PED_MIN);
  localparam logic [CNT_W-1:0] WAIT_T  = CNT_W'(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] ZERO_T  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_T   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_WAIT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             ped_pending_r;

  logic [CNT_W-1:0] wait_next_s;
  logic [CNT_W-1:0] load_ticks_s;
  logic [1:0]       code_phase_s;
  logic             code_illegal_s;
  logic             pend_eff_s;
  logic             run_s;
  logic             load_s;

  // Classify the observed light code; two or more lamps lit is illegal
  always_comb begin
    code_illegal_s = 1'b0;
    code_phase_s   = PH_BLANK;
    case ({r, y, g})
      3'b100:  code_phase_s = PH_RED;
      3'b000:  code_phase_s = PH_BLANK;
      3'b010:  code_phase_s = PH_YEL;
      3'b001:  code_phase_s = PH_GRN;
      default: code_illegal_s = 1'b1;
    endcase
  end

  // Dwell count for the phase currently on the lights
  always_comb begin
    load_ticks_s = GRN_T;
    case (code_phase_s)
      PH_RED:   load_ticks_s = RED_T;
      PH_BLANK: load_ticks_s = BLANK_T;
      PH_YEL:   load_ticks_s = YEL_T;
      PH_GRN:   load_ticks_s = GRN_T;
      default:  load_ticks_s = GRN_T;
    endcase
  end

  // Edge qualification: a request arriving this edge already counts for the green cap
  always_comb begin
    run_s       = 1'b0;
    load_s      = 1'b0;
    wait_next_s = wait_cnt_r + ONE_T;
    pend_eff_s  = ped_pending_r | ped_req;
    if (enable && !code_illegal_s && (state_r != ST_FAULT)) begin
      run_s  = 1'b1;
      load_s = (state_r == ST_IDLE) ||
               ((state_r == ST_WAIT) && (code_phase_s != phase));
    end else begin
      run_s  = 1'b0;
      load_s = 1'b0;
    end
  end

  // Main controller: fault capture, phase load, dwell countdown and advance handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      advance    <= 1'b0;
      phase      <= PH_RED;
      remaining  <= ZERO_T;
      fault      <= 1'b0;
      wait_cnt_r <= ZERO_T;
    end else if (code_illegal_s || (state_r == ST_FAULT)) begin
      state_r <= ST_FAULT;
      fault   <= 1'b1;
      advance <= 1'b0;
    end else if (!run_s) begin
      advance <= 1'b0;
    end else if (load_s) begin
      state_r    <= ST_COUNT;
      phase      <= code_phase_s;
      remaining  <= load_ticks_s;
      wait_cnt_r <= ZERO_T;
      advance    <= 1'b0;
    end else begin
      case (state_r)
        ST_COUNT: begin
          if (remaining == ZERO_T) begin
            advance    <= 1'b1;
            state_r    <= ST_WAIT;
            wait_cnt_r <= ZERO_T;
          end else if ((phase == PH_GRN) && pend_eff_s && (remaining > PED_T)) begin
            advance   <= 1'b0;
            remaining <= PED_T;
          end else begin
            advance   <= 1'b0;
            remaining <= remaining - ONE_T;
          end
        end
        ST_WAIT: begin
          // Sequencer missed the pulse: poke it again and restart the timeout
          if (wait_next_s >= WAIT_T) begin
            advance    <= 1'b1;
            wait_cnt_r <= ZERO_T;
          end else begin
            advance    <= 1'b0;
            wait_cnt_r <= wait_next_s;
          end
        end
        default: begin
          advance <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Pedestrian latch and walk indication; a request during the red load stays pending
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pending_r <= 1'b0;
      ped_walk      <= 1'b0;
    end else if (load_s && (code_phase_s == PH_RED) && ped_pending_r) begin
      ped_walk      <= 1'b1;
      ped_pending_r <= ped_req;
    end else if (load_s && (code_phase_s != PH_RED)) begin
      ped_walk      <= 1'b0;
      ped_pending_r <= pend_eff_s;
    end else begin
      ped_pending_r <= pend_eff_s;
    end
  end

  stoplight_phase_timer_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .fault   (fault)
  );

endmodule

// Invariant checker for the phase timer outputs.
module stoplight_phase_timer_chk (
  input logic clk,
  input logic rst,
  input logic advance,
  input logic fault
);

  a_fault_silences_advance: assert property (@(posedge clk) disable iff (rst) fault |-> !advance);

endmodule
